butterfly_pipe: RTL and testbench

//   Pipelined, parametrised radix-2 butterfly: y0 = x0 + x1, y1 = x0 - x1, complex.
//   Per-sample selectable scaling: none, or halving with round-half-up.

---
 rtl/fft_pkg.sv | 14 +
 rtl/butterfly_sat.sv | 36 +++
 rtl/butterfly_pipe.sv | 139 +++++++++++++
 tb/tb_butterfly_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fft_pkg                                                     |
// | Shared constants for the butterfly datapath: range limits, scaling.  |
// | Rev     : 1.0                                                         |
// +----------------------------------------------------------------------+
package fft_pkg;
  localparam int   FFT_WIDTH  = 16;
  localparam int   MAXV       = 2**(FFT_WIDTH-1) - 1;
  localparam int   MINV       = -(2**(FFT_WIDTH-1));
  localparam logic SCALE_NONE = 1'b0;
  localparam logic SCALE_HALF = 1'b1;
endpackage
`default_nettype wire

// File: rtl/butterfly_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : butterfly_sat                                                |
// | Optional halving, WIDTH+2 -> WIDTH narrowing, overflow flag.          |
// | Config : BUTTERFLY_SAT_EN selects clamp instead of wrap.              |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module butterfly_sat
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+1:0] s,
  input  logic             scale,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic signed [WIDTH+1:0] w_inc;
  logic signed [WIDTH+1:0] w_r;

  always_comb begin
    w_inc = $signed(s) + $signed((WIDTH+2)'(1));
    w_r   = (scale == SCALE_HALF) ? (w_inc >>> 1) : $signed(s);
    // In range iff the top three bits are a pure sign extension
    ovf   = (w_r[WIDTH+1:WIDTH-1] != 3'b000) && (w_r[WIDTH+1:WIDTH-1] != 3'b111);
`ifdef BUTTERFLY_SAT_EN
    if (ovf)
      y = w_r[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      y = w_r[WIDTH-1:0];
`else
    y = w_r[WIDTH-1:0];
`endif
  end
endmodule
`default_nettype wire

// File: rtl/butterfly_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : butterfly_pipe                                               |
// | Pipelined complex radix-2 butterfly with per-frame overflow summary.  |
// | Config : BUTTERFLY_SAT_EN (saturate instead of wrap on overflow).     |
// | Rev    : 1.0                                                          |
// +----------------------------------------------------------------------+
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6,
  parameter int PIPE  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic             scale,
  input  logic [WIDTH-1:0] x0_r,
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] x1_r,
  input  logic [WIDTH-1:0] x1_i,
  output logic             do_en,
  output logic [WIDTH-1:0] y0_r,
  output logic [WIDTH-1:0] y0_i,
  output logic [WIDTH-1:0] y1_r,
  output logic [WIDTH-1:0] y1_i,
  output logic             ovf,
  output logic             frame_done,
  output logic             frame_ovf
);
  function automatic logic [WIDTH+1:0] ext(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Component order throughout: y0_r, y0_i, y1_r, y1_i
  logic [WIDTH+1:0] w_s   [4];
  logic [WIDTH+1:0] r_s   [4];
  logic [WIDTH-1:0] w_y   [4];
  logic [WIDTH-1:0] w_y_out [4];
  logic [3:0]       w_ovf;
  logic             r_scale;
  logic             r_v1;
  logic             w_ovf_out;
  logic             w_vld;

  always_comb begin
    w_s[0] = ext(x0_r) + ext(x1_r);
    w_s[1] = ext(x0_i) + ext(x1_i);
    w_s[2] = ext(x0_r) - ext(x1_r);
    w_s[3] = ext(x0_i) - ext(x1_i);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_v1    <= 1'b0;
      r_scale <= SCALE_NONE;
      for (int k = 0; k < 4; k++) r_s[k] <= '0;
    end else begin
      r_v1 <= di_en;
      if (di_en) begin
        r_s     <= w_s;
        r_scale <= scale;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_sat
    butterfly_sat #(.WIDTH(WIDTH)) u_sat (
      .s     (r_s[k]),
      .scale (r_scale),
      .y     (w_y[k]),
      .ovf   (w_ovf[k])
    );
  end

  if (PIPE == 2) begin : g_pipe2
    logic [WIDTH-1:0] r_y [4];
    logic             r_ovf;
    logic             r_v2;

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_v2  <= 1'b0;
        r_ovf <= 1'b0;
        for (int k = 0; k < 4; k++) r_y[k] <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_y   <= w_y;
          r_ovf <= |w_ovf;
        end
      end
    end

    assign w_y_out   = r_y;
    assign w_ovf_out = r_ovf;
    assign w_vld     = r_v2;
  end else begin : g_pipe1
    // Stage-1 registers only load on di_en, so these hold between valids
    assign w_y_out   = w_y;
    assign w_ovf_out = |w_ovf;
    assign w_vld     = r_v1;
  end

  assign do_en = w_vld;
  assign y0_r  = w_y_out[0];
  assign y0_i  = w_y_out[1];
  assign y1_r  = w_y_out[2];
  assign y1_i  = w_y_out[3];
  assign ovf   = w_ovf_out;

  logic [LOG_N-1:0] r_cnt;
  logic             r_acc;
  logic             r_fovf;
  logic             w_acc_all;

  assign frame_done = w_vld && (r_cnt == '1);
  assign w_acc_all  = r_acc | w_ovf_out;
  // Summary is visible on the frame_done cycle itself, then held
  assign frame_ovf  = frame_done ? w_acc_all : r_fovf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_acc  <= 1'b0;
      r_fovf <= 1'b0;
    end else if (w_vld) begin
      r_cnt <= r_cnt + LOG_N'(1);
      if (frame_done) begin
        r_fovf <= w_acc_all;
        r_acc  <= 1'b0;
      end else begin
        r_acc  <= w_acc_all;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_butterfly_pipe.sv
`default_nettype none
// Bench for butterfly_pipe: PIPE=2 and PIPE=1 instances share stimulus and
// are compared every cycle against a sample-level model plus literal checks.
module tb_butterfly_pipe;
  import fft_pkg::*;
  localparam int W  = 16;
  localparam int LN = 2;

  logic clock = 1'b0, reset = 1'b0, di_en = 1'b0, scale = 1'b0;
  logic [W-1:0] x0_r = '0, x0_i = '0, x1_r = '0, x1_i = '0;

  logic do_a, ovf_a, fd_a, fo_a, do_b, ovf_b, fd_b, fo_b;
  logic [W-1:0] y0r_a, y0i_a, y1r_a, y1i_a, y0r_b, y0i_b, y1r_b, y1i_b;

  always #5 clock = ~clock;

  butterfly_pipe #(.WIDTH(W), .LOG_N(LN), .PIPE(2)) dut_a (
    .clock(clock), .reset(reset), .di_en(di_en), .scale(scale),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i),
    .do_en(do_a), .y0_r(y0r_a), .y0_i(y0i_a), .y1_r(y1r_a), .y1_i(y1i_a),
    .ovf(ovf_a), .frame_done(fd_a), .frame_ovf(fo_a));

  butterfly_pipe #(.WIDTH(W), .LOG_N(LN), .PIPE(1)) dut_b (
    .clock(clock), .reset(reset), .di_en(di_en), .scale(scale),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i),
    .do_en(do_b), .y0_r(y0r_b), .y0_i(y0i_b), .y1_r(y1r_b), .y1_i(y1i_b),
    .ovf(ovf_b), .frame_done(fd_b), .frame_ovf(fo_b));

  typedef struct packed { logic v; logic ovf; logic [3:0][W-1:0] y; } smp_t;
  typedef struct packed { logic de; logic ovf; logic fd; logic fo; logic [3:0][W-1:0] y; } exp_t;

  smp_t p0, p1;
  exp_t ex [2];
  int   cnt [2];
  bit   acc [2];
  bit   fov [2];
  int   checks = 0, errors = 0;
  int   nda = 0, ndb = 0, nfd_a = 0, nfd_b = 0, fdpos_a = 0, fdpos_b = 0;
  logic fo_at_fd_a = 1'b0;

  function automatic int half_floor(input int t);
    return (t >= 0) ? t / 2 : (t - 1) / 2;
  endfunction

  function automatic smp_t model(input bit sc, input int a0r, a0i, a1r, a1i);
    smp_t o;
    int   s [4];
    int   r;
    o = '0;
    s[0] = a0r + a1r; s[1] = a0i + a1i; s[2] = a0r - a1r; s[3] = a0i - a1i;
    for (int k = 0; k < 4; k++) begin
      r = sc ? half_floor(s[k] + 1) : s[k];
      if (r > MAXV || r < MINV) begin
        o.ovf = 1'b1;
`ifdef BUTTERFLY_SAT_EN
        r = (r > MAXV) ? MAXV : MINV;
`endif
      end
      o.y[k] = 16'(r);
    end
    return o;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic cmp(input int d, input logic de, input logic ov, input logic fd, input logic fo,
                     input logic [3:0][W-1:0] y);
    string tag;
    tag = (d == 0) ? "pipe2" : "pipe1";
    chk1({tag, "_do_en"}, de, ex[d].de);
    chk1({tag, "_ovf"}, ov, ex[d].ovf);
    chk1({tag, "_frame_done"}, fd, ex[d].fd);
    chk1({tag, "_frame_ovf"}, fo, ex[d].fo);
    for (int k = 0; k < 4; k++) chk16($sformatf("%s_y%0d", tag, k), y[k], ex[d].y[k]);
  endtask

  task automatic tick();
    smp_t cur, o;
    bit   rn;
    cur   = model(scale, int'($signed(x0_r)), int'($signed(x0_i)),
                  int'($signed(x1_r)), int'($signed(x1_i)));
    cur.v = di_en && reset;
    rn    = reset;
    @(posedge clock);
    #1;
    if (!rn) begin
      p0 = '0; p1 = '0;
      for (int d = 0; d < 2; d++) begin
        ex[d] = '0; cnt[d] = 0; acc[d] = 0; fov[d] = 0;
      end
    end else begin
      p1 = p0; p0 = cur;
      for (int d = 0; d < 2; d++) begin
        o        = (d == 0) ? p1 : p0;
        ex[d].de = o.v;
        ex[d].fd = 1'b0;
        if (o.v) begin
          ex[d].y   = o.y;
          ex[d].ovf = o.ovf;
          ex[d].fd  = (cnt[d] == 2**LN - 1);
          acc[d]    = acc[d] | o.ovf;
          if (ex[d].fd) begin
            fov[d] = acc[d];
            acc[d] = 0;
          end
          cnt[d] = (cnt[d] + 1) % (2**LN);
        end
        ex[d].fo = fov[d];
      end
    end
    cmp(0, do_a, ovf_a, fd_a, fo_a, {y1i_a, y1r_a, y0i_a, y0r_a});
    cmp(1, do_b, ovf_b, fd_b, fo_b, {y1i_b, y1r_b, y0i_b, y0r_b});
    if (do_a) begin
      nda++;
      if (fd_a) begin nfd_a++; fdpos_a = nda; fo_at_fd_a = fo_a; end
    end
    if (do_b) begin
      ndb++;
      if (fd_b) begin nfd_b++; fdpos_b = ndb; end
    end
  endtask

  task automatic drive(input bit v, input bit sc, input logic [W-1:0] a, b, c, d);
    di_en = v; scale = sc; x0_r = a; x0_i = b; x1_r = c; x1_i = d;
  endtask

  function automatic logic [W-1:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'(int'($urandom_range(0, 40)) - 20);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom), rnd16(), rnd16(), rnd16(), rnd16());
      tick();
    end
  endtask

  task automatic clear_mon();
    nda = 0; ndb = 0; nfd_a = 0; nfd_b = 0; fdpos_a = 0; fdpos_b = 0; fo_at_fd_a = 1'b0;
  endtask

  // Four small clean samples with 1-3 idle gaps; index bad_idx overflows
  task automatic frame4(input int bad_idx);
    for (int k = 1; k <= 4; k++) begin
      if (k == bad_idx) drive(1'b1, 1'b0, 16'd20000, 16'd0, 16'd20000, 16'd0);
      else drive(1'b1, 1'($urandom), 16'(k * 10), 16'(k), 16'd3, 16'(-k));
      tick();
      idle($urandom_range(1, 3));
    end
    idle(3);
  endtask

  initial begin
    // reset with di_en asserted
    reset = 1'b0;
    drive(1'b1, 1'b1, 16'd1234, 16'd55, 16'd77, 16'd99);
    tick(); tick();
    chk1("t1_do_en", do_a, 1'b0);
    chk16("t1_y0r", y0r_a, 16'd0);
    chk1("t1_frame_ovf", fo_a, 1'b0);
    reset = 1'b1;
    clear_mon();
    idle(3);
    chk16("t1_stale_do_en", 16'(nda + ndb), 16'd0);

    drive(1'b1, 1'b1, 16'd100, 16'(-50), 16'd30, 16'd20);
    tick();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    chk1("t2_do_en", do_a, 1'b1);
    chk16("t2_y0r", y0r_a, 16'd65);
    chk16("t2_y0i", y0i_a, 16'(-15));
    chk16("t2_y1r", y1r_a, 16'd35);
    chk16("t2_y1i", y1i_a, 16'(-35));
    chk1("t2_ovf", ovf_a, 1'b0);

    drive(1'b1, 1'b1, 16'd32767, 16'd0, 16'h8000, 16'd0);
    tick();
    idle(1);
`ifdef BUTTERFLY_SAT_EN
    chk16("t3_y1r", y1r_a, 16'd32767);
`else
    chk16("t3_y1r", y1r_a, 16'h8000);
`endif
    chk16("t3_y0r", y0r_a, 16'd0);
    chk1("t3_ovf", ovf_a, 1'b1);

    drive(1'b1, 1'b0, 16'd20000, 16'd0, 16'd20000, 16'd0);
    tick();
    idle(1);
`ifdef BUTTERFLY_SAT_EN
    chk16("t4_y0r", y0r_a, 16'd32767);
`else
    chk16("t4_y0r", y0r_a, 16'(-25536));
`endif
    chk16("t4_y1r", y1r_a, 16'd0);
    chk1("t4_ovf", ovf_a, 1'b1);

    // frame summary: dirty frame then clean frame
    reset = 1'b0; idle(1); reset = 1'b1;
    clear_mon();
    frame4(2);
    chk16("t5_fd_pos", 16'(fdpos_a), 16'd4);
    chk16("t5_fd_count", 16'(nfd_a), 16'd1);
    chk1("t5_frame_ovf", fo_at_fd_a, 1'b1);
    clear_mon();
    frame4(0);
    chk16("t5b_fd_pos", 16'(fdpos_a), 16'd4);
    chk1("t5b_frame_ovf", fo_at_fd_a, 1'b0);

    // reset while samples are in flight in both pipelines
    drive(1'b1, 1'b0, 16'd11, 16'd22, 16'd33, 16'd44);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'd5, 16'd6, 16'd7, 16'd8);
    tick();
    reset = 1'b1;
    clear_mon();
    idle(2);
    chk16("t6_no_ghost", 16'(nda + ndb), 16'd0);
    frame4(3);
    chk16("t6_fd_pos_p2", 16'(fdpos_a), 16'd4);
    chk16("t6_fd_pos_p1", 16'(fdpos_b), 16'd4);
    chk16("t6_fd_cnt_p2", 16'(nfd_a), 16'd1);
    chk16("t6_fd_cnt_p1", 16'(nfd_b), 16'd1);

    // randomized traffic, occasional resets
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 60) != 0);
      drive(1'($urandom), 1'($urandom), rnd16(), rnd16(), rnd16(), rnd16());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
